user_stream_block_summer: RTL and testbench
===========================================

Name: user_stream_block_summer

Overview:
- Sits in the user clock domain, directly downstream of the user logic adapter's PCIe-to-user stream FIFO.
- Consumes a 64-bit valid/ack word stream and reduces each block of BLOCK_LEN words to a single 64-bit result.
- Sends the result back through the adapter's user-to-PCIe stream FIFO.
- One instance is attached per stream interface, as a reference accelerator and throughput test load.

Parameters:
BLOCK_LEN, 16, words per block; legal range 1..65535.
CNT_W, 16, width of the internal word counter; must satisfy 2^CNT_W >= BLOCK_LEN.

Ports:
i_user_clk  input  1  user clock; all logic is on its rising edge.
i_rst  input  1  synchronous reset, active-high.
i_mode  input  1  reduction mode: 0 = add (mod 2^64), 1 = XOR. Sampled on the first word of each block.
i_str_data_valid  input  1  input word valid; driven by the adapter's write-FIFO output valid.
o_str_ack  output  1  input ready; a transfer occurs when valid and ack are both high.
i_str_data  input  64  input word.
o_str_data_valid  output  1  result valid.
i_str_ack  input  1  downstream ready; driven by the adapter's read-FIFO input ack.
o_str_data  output  64  block result.
o_blk_count  output  32  number of results delivered since reset; wraps at 2^32.
o_busy  output  1  high while a block is partially accumulated or a result is pending.

Behaviour:
- Reset (i_rst high at a clock edge):
  - state = ACCUM; accumulator = 0; word count = 0.
  - o_str_data = 0, o_str_data_valid = 0, o_blk_count = 0, o_busy = 0.
  - o_str_ack is 1 in the first cycle after reset.
- Reset mid-block or mid-EMIT discards the partial block and the pending result; no output is produced for it.
- States: ACCUM and EMIT.
- o_str_ack = (state == ACCUM); it is combinational from state only and never depends on i_str_data_valid.
- Input handshake: i_str_data_valid & o_str_ack at a rising edge.
- In ACCUM, on each input handshake:
  - If count == 0: latch i_mode into the mode register; the operand used is 0 combined with data (first word = data).
  - next_acc = acc + data (add, carry out discarded) or acc ^ data (XOR), using the latched mode. Word 0 uses the freshly sampled i_mode.
  - If count == BLOCK_LEN-1:
    - o_str_data <= next_acc; o_str_data_valid <= 1; acc <= 0; count <= 0.
    - state <= EMIT.
  - Otherwise: acc <= next_acc; count <= count + 1.
- No handshake in ACCUM: hold all state.
- In EMIT:
  - o_str_ack = 0.
  - o_str_data and o_str_data_valid are held stable until i_str_ack is high.
  - On o_str_data_valid & i_str_ack: o_str_data_valid <= 0; o_blk_count += 1; state <= ACCUM.
  - o_str_data retains its last value after the transfer.
- Latency: the result is valid in the cycle after the last input handshake of the block.
- Throughput: at most one block per BLOCK_LEN+1 cycles (one bubble cycle per block, in EMIT).
- BLOCK_LEN = 1: every input word goes directly to EMIT, with result = data in either mode.
- Changes to i_mode mid-block have no effect on the current block.
- o_busy = (count != 0) | (state == EMIT).
- Data and valid inputs outside a handshake are ignored.
- There is no combinational path from i_str_ack to o_str_ack.

Test Plan:
- Reset, BLOCK_LEN = 4, add mode, input words 1, 2, 3, 4 back-to-back, i_str_ack held high:
  - o_str_ack is high for 4 cycles, then low for 1 cycle.
  - o_str_data = 0x000000000000000A is valid in the cycle after word 4.
  - o_blk_count becomes 1.
- Add wrap: words 0xFFFFFFFFFFFFFFFF, 2, 0, 0 -> result 0x0000000000000001 (carry discarded).
- XOR mode: i_mode = 1 at word 0, words 0xF0F0, 0x0FF0, 0x1, 0x1; i_mode toggled to 0 at word 2 -> result 0xFF00 (XOR still applied).
- Backpressure: hold i_str_ack low for 10 cycles after the result:
  - o_str_data_valid stays 1 and o_str_data is stable.
  - o_str_ack stays 0 and an offered input word is not consumed.
  - On release: one transfer, then input accepted again in the next cycle.
- Sparse input: i_str_data_valid toggling randomly over 3 blocks -> results match the software model and o_blk_count = 3; o_busy drops to 0 after the last result transfers.
- Reset mid-operation:
  - Assert i_rst after 2 of 4 words -> all outputs return to reset values.
  - The next 4 words 5, 5, 5, 5 give result 0x14 with no residue from the aborted block.
  - Repeat with i_rst asserted during EMIT -> the pending result is dropped and o_blk_count = 0.

Source files
------------

// File: rtl/user_stream_block_summer.sv
// user_stream_block_summer: reduces each BLOCK_LEN-word input block to one 64-bit sum or XOR result.
module user_stream_block_summer #(
    parameter int BLOCK_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic        i_user_clk,
    input  logic        i_rst,
    input  logic        i_mode,
    input  logic        i_str_data_valid,
    output logic        o_str_ack,
    input  logic [63:0] i_str_data,
    output logic        o_str_data_valid,
    input  logic        i_str_ack,
    output logic [63:0] o_str_data,
    output logic [31:0] o_blk_count,
    output logic        o_busy
);
    typedef enum logic {ACCUM, EMIT} state_t;
    state_t            state;
    logic [63:0]       acc;
    logic [CNT_W-1:0]  count;
    logic              mode;
    logic              first, last, eff_mode;
    logic [63:0]       base, next_acc;
    assign o_str_ack = state == ACCUM;
    assign o_busy    = (count != '0) | (state == EMIT);
    assign first     = count == '0;
    assign last      = count == CNT_W'(BLOCK_LEN - 1);
    // Word 0 uses the live mode input; later words use the mode latched at word 0.
    assign eff_mode  = first ? i_mode : mode;
    assign base      = first ? '0 : acc;
    assign next_acc  = eff_mode ? base ^ i_str_data : base + i_str_data;
    always_ff @(posedge i_user_clk) begin
        if (i_rst) begin
            state            <= ACCUM;
            acc              <= '0;
            count            <= '0;
            mode             <= 1'b0;
            o_str_data       <= '0;
            o_str_data_valid <= 1'b0;
            o_blk_count      <= '0;
        end else if (state == ACCUM) begin
            if (i_str_data_valid) begin
                if (first) mode <= i_mode;
                if (last) begin
                    o_str_data       <= next_acc;
                    o_str_data_valid <= 1'b1;
                    acc              <= '0;
                    count            <= '0;
                    state            <= EMIT;
                end else begin
                    acc   <= next_acc;
                    count <= count + CNT_W'(1);
                end
            end
        end else if (i_str_ack) begin
            o_str_data_valid <= 1'b0;
            o_blk_count      <= o_blk_count + 32'd1;
            state            <= ACCUM;
        end
    end
endmodule

// File: tb/tb_user_stream_block_summer.sv
// tb_user_stream_block_summer: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_user_stream_block_summer;
    logic        clk = 0, rst = 1, mode = 0, in_valid = 0, in_ack, out_valid, out_ack = 1, busy;
    logic [63:0] in_data = '0, out_data;
    logic [31:0] blk_count;
    logic [63:0] exp_q[$];
    int          checks = 0, errors = 0;

    user_stream_block_summer #(.BLOCK_LEN(4), .CNT_W(16)) dut (
        .i_user_clk(clk), .i_rst(rst), .i_mode(mode),
        .i_str_data_valid(in_valid), .o_str_ack(in_ack), .i_str_data(in_data),
        .o_str_data_valid(out_valid), .i_str_ack(out_ack), .o_str_data(out_data),
        .o_blk_count(blk_count), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a result transfers at the next rising edge when valid and ack are both high.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ack) begin
            if (exp_q.size() == 0) chk("unexpected_result", out_data, 64'hx);
            else chk("result", out_data, exp_q.pop_front());
        end
    end

    task automatic send(input logic [63:0] d, input logic m);
        int n = 0;
        @(negedge clk);
        in_valid = 1; in_data = d; mode = m;
        while (!in_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ack) begin
            checks++; errors++;
            $display("FAIL send_timeout: input not accepted, ack %b required 1", in_ack);
        end else @(posedge clk);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        in_valid = 0;
        while ((out_valid || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_busy"}, busy, 0);
        chk({name, "_valid"}, out_valid, 0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_data"}, out_data, 0);
        chk({name, "_valid"}, out_valid, 0);
        chk({name, "_blk"}, blk_count, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_ack"}, in_ack, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        chk_reset("reset");
        // Basic add block: 1+2+3+4
        exp_q.push_back(64'hA);
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        @(negedge clk);
        in_valid = 0;
        chk("t1_ack_low", in_ack, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 64'hA);
        @(negedge clk);
        chk("t1_ack_high", in_ack, 1);
        chk("t1_blk", blk_count, 1);
        chk("t1_busy", busy, 0);
        // Carry wrap
        exp_q.push_back(64'h1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 0); send(2, 0); send(0, 0); send(0, 0);
        // XOR with mode flipped mid-block
        exp_q.push_back(64'hFF00);
        send(64'hF0F0, 1); send(64'h0FF0, 1); send(1, 0); send(1, 0);
        wait_idle("t3");
        chk("t3_blk", blk_count, 3);
        // Backpressure
        out_ack = 0;
        exp_q.push_back(64'h4);
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        repeat (10) begin
            @(negedge clk);
            in_valid = 1; in_data = 64'h99; mode = 0;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 64'h4);
            chk("bp_ack", in_ack, 0);
        end
        out_ack = 1;
        @(negedge clk);
        chk("bp_ack_back", in_ack, 1);
        chk("bp_blk", blk_count, 4);
        chk("bp_valid_drop", out_valid, 0);
        exp_q.push_back(64'h9C);
        @(posedge clk);
        send(1, 0); send(1, 0); send(1, 0);
        wait_idle("bp_end");
        chk("bp_blk2", blk_count, 5);
        // Sparse input over three blocks from a fresh reset
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        exp_q.push_back(64'h64);
        exp_q.push_back(64'h0F);
        exp_q.push_back(64'hB);
        send(10, 0); gap($urandom_range(0, 3)); send(20, 0); gap($urandom_range(0, 3));
        send(30, 0); gap($urandom_range(0, 3)); send(40, 0); gap($urandom_range(0, 3));
        send(64'hAA, 1); gap($urandom_range(0, 3)); send(64'h55, 0); gap($urandom_range(0, 3));
        send(64'hFF, 0); gap($urandom_range(0, 3)); send(64'h0F, 1); gap($urandom_range(0, 3));
        send(64'h8000_0000_0000_0000, 0); gap($urandom_range(0, 3));
        send(64'h8000_0000_0000_0000, 1); gap($urandom_range(0, 3));
        send(5, 1); gap($urandom_range(0, 3)); send(6, 1);
        wait_idle("sparse");
        chk("sparse_blk", blk_count, 3);
        chk("sparse_data", out_data, 64'hB);
        // Reset mid-block
        send(7, 0); send(7, 0);
        @(negedge clk);
        in_valid = 0;
        chk("mid_busy", busy, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_reset("mid_rst");
        exp_q.push_back(64'h14);
        send(5, 0); send(5, 0); send(5, 0); send(5, 0);
        wait_idle("after_mid");
        chk("after_mid_blk", blk_count, 1);
        // Reset while a result is pending
        out_ack = 0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        @(negedge clk);
        in_valid = 0;
        chk("emit_pending", out_valid, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        out_ack = 1;
        chk_reset("emit_rst");
        exp_q.push_back(64'h14);
        send(5, 0); send(5, 0); send(5, 0); send(5, 0);
        wait_idle("final");
        chk("final_blk", blk_count, 1);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
